// File: rtl/dds_pkg.sv
// Shared constants and FSM encoding for the DDS command parser.
// Frame: SOF, CMD, DATA_H, DATA_L, CHK with CHK = CMD ^ DATA_H ^ DATA_L.
package dds_pkg;

    localparam logic [7:0] SOF        = 8'h55;
    localparam logic [7:0] ACK        = 8'h06;
    localparam logic [7:0] NAK        = 8'h15;
    localparam logic [7:0] CMD_COMMIT = 8'h0F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DH,
        ST_DL,
        ST_CHK,
        ST_EXEC,
        ST_RESP
    } state_t;

    function automatic logic cmd_legal(input logic [7:0] c);
        return (c >= 8'h01 && c <= 8'h04) || c == CMD_COMMIT;
    endfunction

endpackage

// File: rtl/byte_timer.sv
// Inter-byte timeout counter; expired holds once TIMEOUT_CYC idle cycles pass.
// The counter parks at its terminal value until cleared or disabled.
module byte_timer #(
    parameter int unsigned TIMEOUT_CYC = 500000
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt;

    assign expired = enable && (cnt >= LAST);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            cnt <= '0;
        else if (clear || !enable)
            cnt <= '0;
        else if (!expired)
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/dds_cmd_parser.sv
// UART command parser: writes shadow DDS phases, commits them to the
// active outputs, and answers every checked frame with ACK or NAK.
module dds_cmd_parser
    import dds_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 500000
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       RX_Done_Sig,
    input  logic [7:0] RX_Data,
    output logic       RX_En_Sig,
    input  logic       TX_Busy,
    output logic       TX_Start,
    output logic [7:0] TX_Data,
    output logic [9:0] phase_1,
    output logic [9:0] phase_2,
    output logic [9:0] phase_3,
    output logic [9:0] phase_4,
    output logic       update_pulse,
    output logic [7:0] err_cnt
);

    state_t     state, state_n;
    logic [7:0] cmd_q, dh_q, dl_q, chk_q;
    logic [7:0] resp_q;
    logic [9:0] shadow [4];
    logic [9:0] phase  [4];
    logic       rx_en_q, upd_q;
    logic       tmr_en, expired, timeout;
    logic       frame_ok, err_inc;

    byte_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .clear   (RX_Done_Sig),
        .enable  (tmr_en),
        .expired (expired)
    );

    assign frame_ok = (chk_q == (cmd_q ^ dh_q ^ dl_q)) && cmd_legal(cmd_q);
    assign err_inc  = timeout || (state == ST_EXEC && !frame_ok);

    always_comb begin
        state_n  = state;
        tmr_en   = 1'b0;
        timeout  = 1'b0;
        TX_Start = 1'b0;
        unique case (state)
            ST_IDLE:
                if (RX_Done_Sig && RX_Data == SOF) state_n = ST_CMD;
            ST_CMD, ST_DH, ST_DL, ST_CHK: begin
                tmr_en = 1'b1;
                // A byte arriving on the expiry cycle still wins.
                if (RX_Done_Sig) begin
                    unique case (state)
                        ST_CMD:  state_n = ST_DH;
                        ST_DH:   state_n = ST_DL;
                        ST_DL:   state_n = ST_CHK;
                        default: state_n = ST_EXEC;
                    endcase
                end else if (expired) begin
                    timeout = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_EXEC:
                state_n = ST_RESP;
            ST_RESP:
                if (!TX_Busy) begin
                    TX_Start = 1'b1;
                    state_n  = ST_IDLE;
                end
            default:
                state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state   <= ST_IDLE;
            cmd_q   <= '0;
            dh_q    <= '0;
            dl_q    <= '0;
            chk_q   <= '0;
            resp_q  <= '0;
            rx_en_q <= 1'b0;
            upd_q   <= 1'b0;
            err_cnt <= '0;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= '0;
                phase[i]  <= '0;
            end
        end else begin
            state   <= state_n;
            rx_en_q <= 1'b1;
            upd_q   <= 1'b0;
            if (RX_Done_Sig) begin
                if (state == ST_CMD) cmd_q <= RX_Data;
                if (state == ST_DH)  dh_q  <= RX_Data;
                if (state == ST_DL)  dl_q  <= RX_Data;
                if (state == ST_CHK) chk_q <= RX_Data;
            end
            if (state == ST_EXEC) begin
                resp_q <= frame_ok ? ACK : NAK;
                if (frame_ok && cmd_q == CMD_COMMIT) begin
                    upd_q <= 1'b1;
                    for (int i = 0; i < 4; i++)
                        phase[i] <= shadow[i];
                end else if (frame_ok) begin
                    for (int i = 0; i < 4; i++)
                        if (cmd_q == 8'(i + 1))
                            shadow[i] <= {dh_q[1:0], dl_q};
                end
            end
            if (err_inc && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end

    assign RX_En_Sig    = rx_en_q;
    assign update_pulse = upd_q;
    assign TX_Data      = resp_q;
    assign phase_1      = phase[0];
    assign phase_2      = phase[1];
    assign phase_3      = phase[2];
    assign phase_4      = phase[3];

endmodule

// File: tb/tb_dds_cmd_parser.sv
// Directed bench for dds_cmd_parser with a TX response scoreboard
// and a small reference model of shadow/active phases and err_cnt.
module tb_dds_cmd_parser;

    localparam int unsigned T = 40;

    logic       CLK = 0;
    logic       RSTn = 0;
    logic       RX_Done_Sig = 0;
    logic [7:0] RX_Data = 0;
    logic       RX_En_Sig;
    logic       TX_Busy = 0;
    logic       TX_Start;
    logic [7:0] TX_Data;
    logic [9:0] phase_1, phase_2, phase_3, phase_4;
    logic       update_pulse;
    logic [7:0] err_cnt;

    dds_cmd_parser #(.TIMEOUT_CYC(T)) dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .RX_Done_Sig  (RX_Done_Sig),
        .RX_Data      (RX_Data),
        .RX_En_Sig    (RX_En_Sig),
        .TX_Busy      (TX_Busy),
        .TX_Start     (TX_Start),
        .TX_Data      (TX_Data),
        .phase_1      (phase_1),
        .phase_2      (phase_2),
        .phase_3      (phase_3),
        .phase_4      (phase_4),
        .update_pulse (update_pulse),
        .err_cnt      (err_cnt)
    );

    always #5 CLK = ~CLK;

    int         vec = 0;
    int         miss = 0;
    logic [7:0] sb [$];
    int         tx_cnt = 0;
    int         upd_cnt = 0;
    logic [9:0] prev_p1 = 0;
    logic       p1_upd = 0;

    logic [9:0] m_sh [4];
    logic [9:0] m_ph [4];
    logic [7:0] m_err;
    int         m_upd;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (TX_Start) begin
            tx_cnt++;
            if (sb.size() == 0)
                chk("tx_unexpected", sb.size(), 1);
            else
                chk("tx_data", TX_Data, sb.pop_front());
        end
        if (update_pulse) upd_cnt++;
        if (phase_1 !== prev_p1) p1_upd = update_pulse;
        prev_p1 = phase_1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_sh[i] = 0;
            m_ph[i] = 0;
        end
        m_err = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        RX_Data = b;
        RX_Done_Sig = 1;
        tick();
        RX_Done_Sig = 0;
    endtask

    task automatic send_frame(input logic [7:0] c, h, l, k,
                              input bit push);
        logic ok;
        ok = (k == (c ^ h ^ l)) &&
             (c inside {8'h01, 8'h02, 8'h03, 8'h04, 8'h0F});
        if (ok && c == 8'h0F) begin
            for (int i = 0; i < 4; i++) m_ph[i] = m_sh[i];
            m_upd++;
        end else if (ok) begin
            m_sh[c - 1] = {h[1:0], l};
        end else if (m_err != 8'hFF) begin
            m_err++;
        end
        if (push) sb.push_back(ok ? 8'h06 : 8'h15);
        send_byte(8'h55);
        send_byte(c);
        send_byte(h);
        send_byte(l);
        send_byte(k);
    endtask

    task automatic wait_tx();
        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            chk("tx_wait", sb.size(), 0);
            sb.delete();
        end
        tick();
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_p1"}, phase_1, m_ph[0]);
        chk({tag, "_p2"}, phase_2, m_ph[1]);
        chk({tag, "_p3"}, phase_3, m_ph[2]);
        chk({tag, "_p4"}, phase_4, m_ph[3]);
        chk({tag, "_err"}, err_cnt, m_err);
        chk({tag, "_upd"}, upd_cnt, m_upd);
    endtask

    task automatic check_zero(input string tag);
        @(negedge CLK);
        chk({tag, "_phases"}, {phase_1, phase_2, phase_3}, 0);
        chk({tag, "_p4"}, phase_4, 0);
        chk({tag, "_err"}, err_cnt, 0);
        chk({tag, "_ctl"}, {TX_Start, update_pulse, RX_En_Sig}, 0);
        chk({tag, "_txd"}, TX_Data, 0);
    endtask

    int n;

    initial begin
        model_reset();
        m_upd = 0;
        repeat (3) tick();
        check_zero("por");
        tick();
        RSTn = 1;
        tick();
        tick();
        chk("rx_en", RX_En_Sig, 1);

        send_frame(8'h01, 8'h01, 8'h23, 8'h23, 1);
        wait_tx();
        check_regs("wr1");
        send_frame(8'h0F, 8'h00, 8'h00, 8'h0F, 1);
        wait_tx();
        check_regs("commit1");
        chk("p1_with_upd", p1_upd, 1);

        send_frame(8'h02, 8'h00, 8'h10, 8'h11, 1);
        wait_tx();
        check_regs("badchk");
        send_frame(8'h0F, 8'h00, 8'h00, 8'h0F, 1);
        wait_tx();
        check_regs("commit2");

        send_frame(8'h07, 8'h00, 8'h00, 8'h07, 1);
        wait_tx();
        check_regs("badcmd");

        n = tx_cnt;
        send_byte(8'h55);
        send_byte(8'h03);
        repeat (T + 10) tick();
        if (m_err != 8'hFF) m_err++;
        chk("to_no_tx", tx_cnt, n);
        check_regs("timeout");
        send_frame(8'h03, 8'h00, 8'h40, 8'h43, 1);
        wait_tx();
        check_regs("after_to");

        sb.push_back(8'h06);
        send_byte(8'h55);
        repeat (T - 2) tick();
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h55);
        send_byte(8'h50);
        m_sh[3] = 10'h155;
        wait_tx();
        check_regs("edge_byte");

        TX_Busy = 1;
        n = tx_cnt;
        send_frame(8'h0F, 8'h00, 8'h00, 8'h0F, 1);
        repeat (100) tick();
        chk("busy_hold", tx_cnt, n);
        TX_Busy = 0;
        @(negedge CLK);
        chk("busy_fall_start", TX_Start, 1);
        chk("busy_fall_data", TX_Data, 8'h06);
        tick();
        tick();
        chk("busy_once", tx_cnt, n + 1);
        check_regs("busy");

        send_byte(8'h55);
        send_byte(8'h04);
        send_byte(8'h00);
        RSTn = 0;
        model_reset();
        check_zero("rst_mid");
        tick();
        RSTn = 1;
        send_frame(8'h04, 8'hFF, 8'h80, 8'h7B, 1);
        wait_tx();
        send_frame(8'h0F, 8'h00, 8'h00, 8'h0F, 1);
        wait_tx();
        check_regs("post_rst");

        TX_Busy = 1;
        n = tx_cnt;
        send_frame(8'h02, 8'h00, 8'h10, 8'h12, 0);
        repeat (5) tick();
        RSTn = 0;
        model_reset();
        tick();
        RSTn = 1;
        TX_Busy = 0;
        repeat (20) tick();
        chk("rst_resp_no_tx", tx_cnt, n);
        check_regs("rst_resp");

        for (int i = 0; i < 260; i++) begin
            send_frame(8'h01, 8'h00, 8'h00, 8'h00, 1);
            wait_tx();
        end
        check_regs("sat");

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
